// File: rtl/rf_pkg.sv
// Shared widths and helpers for the decode-stage register file with busy scoreboard.
package rf_pkg;

  localparam int unsigned RF_ADDR_WIDTH = 5;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned ZERO_IDX      = 0;

  // Low bit of port `port` inside a packed multi-port bus of `width`-bit slices.
  function automatic int unsigned slice_lo(int unsigned port, int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/onehot_write_decoder.sv
// Binary index to one-hot enable vector, with optional masking of the zero register.
module onehot_write_decoder
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter bit          ZERO_MASK  = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic                       en,
  output logic [(2**ADDR_WIDTH)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[addr] = 1'b1;
    end
    if (ZERO_MASK) begin
      onehot[ZERO_IDX] = 1'b0;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with combinational read ports, write bypass and a per-register busy scoreboard.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter int unsigned NUM_READ   = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           we,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           mark,
  input  logic [ADDR_WIDTH-1:0]          mark_addr,
  input  logic                           flush,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  output logic                           any_busy,
  output logic [ADDR_WIDTH:0]            busy_cnt
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int unsigned CW       = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [NUM_REGS-1:0]   wen, mset;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  inc, dec;

  onehot_write_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_MASK  (ZERO_REG)
  ) u_wb_dec (
    .addr   (waddr),
    .en     (we),
    .onehot (wen)
  );

  // Flush suppresses marks at the source so the counter never sees them.
  onehot_write_decoder #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_MASK  (ZERO_REG)
  ) u_mark_dec (
    .addr   (mark_addr),
    .en     (mark & ~flush),
    .onehot (mset)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wen[k]) begin
          regs_q[k] <= wdata;
        end
      end
    end
  end

  // A same-cycle mark beats writeback: the new producer is still outstanding.
  always_comb begin
    inc    = |(mset & ~busy_q);
    dec    = |(wen & ~mset & busy_q);
    busy_d = (busy_q & ~wen) | mset;
    cnt_d  = cnt_q + CW'(inc) - CW'(dec);
    if (flush) begin
      busy_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_cnt = cnt_q;
  assign any_busy = (cnt_q != '0);

  for (genvar i = 0; i < NUM_READ; i++) begin : g_read
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  is_zero;
    logic                  hit;

    assign ra      = raddr[slice_lo(i, ADDR_WIDTH) +: ADDR_WIDTH];
    assign is_zero = ZERO_REG && (ra == ADDR_WIDTH'(ZERO_IDX));
    assign hit     = BYPASS && we && (waddr == ra);

    always_comb begin
      rd = regs_q[ra];
      if (is_zero) begin
        rd = '0;
      end else if (hit) begin
        rd = wdata;
      end
    end

    assign rdata[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH] = rd;
    assign rbusy[i] = busy_q[ra] & ~hit;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised register file with an internal one-hot write decoder, configurable read-port count, optional hardwired-zero register, optional write-to-read bypass, and a per-register busy scoreboard. Sits in the decode stage of the pipelined core. The scoreboard is set when an instruction with a destination register issues, and cleared when its result is written back. Hazard logic consumes the per-port busy flags.

Parameters:
ADDR_WIDTH, 5, register index width; NUM_REGS = 2**ADDR_WIDTH
DATA_WIDTH, 32, register data width
NUM_READ, 2, number of combinational read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes/marks
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all registers and busy bits
we  in  1  writeback enable
waddr  in  ADDR_WIDTH  writeback register index
wdata  in  DATA_WIDTH  writeback data
mark  in  1  issue strobe: set busy for mark_addr
mark_addr  in  ADDR_WIDTH  destination index of issuing instruction
flush  in  1  synchronous clear of all busy bits
raddr  in  NUM_READ*ADDR_WIDTH  packed read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
rdata  out  NUM_READ*DATA_WIDTH  packed read data, same packing
rbusy  out  NUM_READ  busy flag of the register addressed by each read port
any_busy  out  1  OR of all busy bits
busy_cnt  out  ADDR_WIDTH+1  number of busy registers

Behaviour:
- Reset, asynchronous: all registers = 0; busy = 0; busy_cnt = 0; any_busy = 0. Reset asserted mid-operation discards pending writes and marks immediately.
- Write decode: wen = we ? (1 << waddr) : 0. When ZERO_REG = 1, bit 0 is masked. Register k loads wdata on the rising edge when wen[k] = 1. One-cycle write latency.
- Reads are combinational: rdata_i = reg[raddr_i].
  - ZERO_REG = 1 and raddr_i == 0: rdata_i = 0, regardless of bypass.
  - BYPASS = 1, we = 1, waddr == raddr_i, raddr_i nonzero (or ZERO_REG = 0): rdata_i = wdata.
  - Multiple ports may address the same register; each is resolved independently.
- Scoreboard, per register k, next-state priority:
  - flush = 1: busy[k] <= 0, marks ignored that cycle.
  - mark = 1 and mark_addr == k: busy[k] <= 1. This takes priority over a same-cycle write to k, because a new producer is outstanding.
  - we = 1 and waddr == k: busy[k] <= 0.
  - Otherwise: hold.
- ZERO_REG = 1: mark and we to register 0 never set or clear busy[0]; busy[0] is constantly 0.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Marking an already-busy register keeps it 1. No counting of multiple producers.
- rbusy_i = busy[raddr_i], except forced 0 when BYPASS = 1, we = 1 and waddr == raddr_i (value available this cycle). The flag is not updated by a same-cycle mark; the new busy is visible next cycle.
- busy_cnt is a registered counter updated alongside busy.
  - Next value = popcount of next busy vector; it must never underflow or exceed NUM_REGS (or NUM_REGS-1 when ZERO_REG = 1).
  - Implemented incrementally: +1 on an effective set of a clear bit, -1 on an effective clear of a set bit. Both may occur in the same cycle (net 0).
  - Reset by flush to 0.
- any_busy = (busy_cnt != 0).

Decomposition:
- Package rf_pkg: default widths (RF_ADDR_WIDTH = 5, RF_DATA_WIDTH = 32), ZERO_IDX constant, and a function for the packed-slice index.
- Sub-module onehot_write_decoder, parametrised by ADDR_WIDTH and ZERO_MASK: inputs addr and en, output one-hot vector of width 2**ADDR_WIDTH. It is instantiated twice: once for writeback clear/load, once for mark set.

Test Plan:
- Reset, then read all 32 indices on both ports -> rdata = 0, rbusy = 0, busy_cnt = 0, any_busy = 0.
- Write 0xDEADBEEF to x5, next cycle raddr0 = 5 -> rdata0 = 0xDEADBEEF. Write 0x1234 to x0 -> reading x0 returns 0; mark x0 -> busy_cnt stays 0.
- Bypass: we = 1, waddr = 7, wdata = 0xA5A5A5A5, raddr1 = 7 in the same cycle -> rdata1 = 0xA5A5A5A5, rbusy1 = 0. Repeat with BYPASS = 0 -> rdata1 shows the old value.
- Scoreboard: mark x3, then x4 -> busy_cnt = 2, rbusy for x3 = 1. Write x3 -> busy_cnt = 1. Same cycle mark x4 and write x4 -> x4 stays busy, busy_cnt = 1.
- Flush with mark x9 in the same cycle -> busy_cnt = 0, any_busy = 0, x9 not busy. Mark all 31 nonzero registers across consecutive cycles -> busy_cnt = 31.
- Assert reset asynchronously mid-cycle with x6 holding 0x55 and 3 registers busy -> registers and busy clear immediately, without waiting for a clock edge.
